pipelined_add_sub: RTL and testbench
====================================

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values 8..64.
REQ-002 Parameter STAGES, default 4, pipeline depth; 1..8; WIDTH SHALL be divisible by STAGES; illegal values SHALL stop elaboration.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  signed operand A.
REQ-008 b  input  WIDTH  signed operand B.
REQ-009 cin  input  1  carry-in, add mode only.
REQ-010 sub  input  1  0 = A+B+cin; 1 = A-B (cin ignored).
REQ-011 sat  input  1  1 = clamp result on signed overflow.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sum  output  WIDTH  signed result.
REQ-015 cout  output  1  carry out of MSB of raw sum.
REQ-016 overflow  output  1  signed overflow flag for the beat.

Function
REQ-017 Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
REQ-018 Operand B' = sub ? ~b : b; carry-in c0 = sub ? 1 : cin; raw = a + B' + c0 over WIDTH+1 bits.
REQ-019 Carry chain SHALL be split into STAGES slices of WIDTH/STAGES bits; slice k computed in stage k, its carry registered into stage k+1; unprocessed operand slices and sub/sat carried alongside.
REQ-020 cout SHALL equal bit WIDTH of raw.
REQ-021 overflow SHALL be 1 iff a[MSB] == B'[MSB] and raw[MSB-1:0] MSB differs from a[MSB].
REQ-022 sat=0: sum = raw[WIDTH-1:0]; sat=1 and overflow: sum = most positive value if a[MSB]=0, else most negative; overflow still reported 1.
REQ-023 Latency: accepted beat appears on out_valid exactly STAGES cycles later absent stalls; throughput one beat per cycle.
REQ-024 Stall: when out_valid && !out_ready, entire pipeline holds; in_ready = !(out_valid && !out_ready) (registered-free, combinational from output stage).
REQ-025 Bubbles: stage valid bits advance when not stalled; empty stages SHALL not block acceptance.
REQ-026 sum/cout/overflow SHALL remain stable while out_valid && !out_ready.
REQ-027 Beat order SHALL be preserved; no beat dropped or duplicated.
REQ-028 STAGES=1: single register stage, full-width add, same handshake.

Reset
REQ-029 On rst high: all stage valid bits, out_valid, sum, cout, overflow cleared to 0 immediately, independent of clk.
REQ-030 Beats in flight at reset SHALL be discarded; in_ready SHALL be 1 during and after reset.
REQ-031 First beat may be accepted on the first rising clk edge after rst deasserts.

Verification
REQ-032 WIDTH=32: a=2147483647, b=1, cin=0, sub=0, sat=0 -> after 4 cycles sum=-2147483648, overflow=1, cout=0; with sat=1 -> sum=2147483647, overflow=1.
REQ-033 a=-2147483648, b=1, sub=1, sat=0 -> sum=2147483647, overflow=1, cout=1; sat=1 -> sum=-2147483648.
REQ-034 Stream 8 back-to-back beats (52+-31, 152+2539, -495955+-4548, -451+4498, 4561+-89, 0+0, -1+1 cin=1, 100-100 sub) with out_ready=1 -> results 21, 2691, -500503, 4047, 4472, 0, 1, 0 in order, one per cycle, overflow=0 each.
REQ-035 Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 after pipeline fills, outputs frozen, no loss; release -> remaining beats in order.
REQ-036 Assert rst asynchronously with 3 beats in flight -> out_valid=0, sum=0 same cycle, no stale beat after release.
REQ-037 Repeat REQ-034 with WIDTH=16, STAGES=1 and WIDTH=64, STAGES=8 -> bit-exact vs. reference model, latency 1 and 8.

Source files
------------

// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
// The slave side is the adder; the master side drives operands and accepts results.
interface pipelined_add_sub_if #(
  parameter int unsigned WIDTH = 32
);

  // Operand side
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    cin;
  logic                    sub;
  logic                    sat;

  // Result side
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] sum;
  logic                    cout;
  logic                    overflow;

  modport slave (
    input  in_valid, a, b, cin, sub, sat, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

  modport master (
    output in_valid, a, b, cin, sub, sat, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined signed adder/subtractor. The carry chain is cut into STAGES
// slices; slice k is resolved in stage k and its carry is registered into
// stage k+1. The last stage also derives overflow and optional saturation.
// A stalled output freezes the whole pipeline.
module pipelined_add_sub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_add_sub_if.slave   io
);

  // Stop elaboration on an unsupported configuration
  if (WIDTH < 8 || WIDTH > 64 || STAGES < 1 || STAGES > 8 ||
      (WIDTH % ((STAGES == 0) ? 1 : STAGES)) != 0) begin : g_bad_params
    $error("pipelined_add_sub: illegal WIDTH/STAGES combination");
  end

  localparam int unsigned SLICE = WIDTH / ((STAGES == 0) ? 1 : STAGES);
  localparam int unsigned MSB   = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Output-stage valid; the only source of back-pressure
  logic w_stall;
  logic r_out_vld;

  assign w_stall     = r_out_vld && !io.out_ready;
  assign io.in_ready = !w_stall;

  // Inputs to stage k: element 0 comes from the port, k>0 from stage k-1
  logic             w_vld [STAGES];
  logic [WIDTH-1:0] w_a   [STAGES];
  logic [WIDTH-1:0] w_bp  [STAGES];
  logic [WIDTH-1:0] w_res [STAGES];
  logic             w_cy  [STAGES];
  logic             w_sat [STAGES];

  // Subtraction is a + ~b + 1, so cin is replaced by 1 in that mode
  assign w_vld[0] = io.in_valid;
  assign w_a[0]   = io.a;
  assign w_bp[0]  = io.sub ? ~io.b : io.b;
  assign w_res[0] = '0;
  assign w_cy[0]  = io.sub | io.cin;
  assign w_sat[0] = io.sat;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SLICE;

    logic [SLICE:0]   w_slc;
    logic [WIDTH-1:0] w_raw;

    // Resolve this stage's slice of the carry chain
    assign w_slc = {1'b0, w_a[k][LO +: SLICE]} + {1'b0, w_bp[k][LO +: SLICE]} +
                   {{SLICE{1'b0}}, w_cy[k]};

    // Merge the new slice into the partial raw sum
    always_comb begin
      w_raw              = w_res[k];
      w_raw[LO +: SLICE] = w_slc[SLICE-1:0];
    end

    if (k + 1 < STAGES) begin : g_mid
      logic             r_vld;
      logic             r_cy;
      logic             r_sat;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_bp;
      logic [WIDTH-1:0] r_res;

      // Advance valid and operands together unless the output is stalled
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= 1'b0;
          r_cy  <= 1'b0;
          r_sat <= 1'b0;
          r_a   <= '0;
          r_bp  <= '0;
          r_res <= '0;
        end else if (!w_stall) begin
          r_vld <= w_vld[k];
          if (w_vld[k]) begin
            r_cy  <= w_slc[SLICE];
            r_sat <= w_sat[k];
            r_a   <= w_a[k];
            r_bp  <= w_bp[k];
            r_res <= w_raw;
          end
        end
      end

      assign w_vld[k+1] = r_vld;
      assign w_cy[k+1]  = r_cy;
      assign w_sat[k+1] = r_sat;
      assign w_a[k+1]   = r_a;
      assign w_bp[k+1]  = r_bp;
      assign w_res[k+1] = r_res;
    end else begin : g_last
      logic             w_ovf;
      logic [WIDTH-1:0] w_sum;
      logic             r_cout;
      logic             r_ovf;
      logic [WIDTH-1:0] r_sum;

      // Signed overflow: like-signed operands producing a sign flip; clamp toward a's sign
      always_comb begin
        w_ovf = (w_a[k][MSB] == w_bp[k][MSB]) && (w_raw[MSB] != w_a[k][MSB]);
        w_sum = w_raw;
        if (w_sat[k] && w_ovf) begin
          w_sum = w_a[k][MSB] ? SMIN : SMAX;
        end
      end

      // Output register; held while the consumer is not ready
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out_vld <= 1'b0;
          r_sum     <= '0;
          r_cout    <= 1'b0;
          r_ovf     <= 1'b0;
        end else if (!w_stall) begin
          r_out_vld <= w_vld[k];
          if (w_vld[k]) begin
            r_sum  <= w_sum;
            r_cout <= w_slc[SLICE];
            r_ovf  <= w_ovf;
          end
        end
      end

      assign io.out_valid = r_out_vld;
      assign io.sum       = r_sum;
      assign io.cout      = r_cout;
      assign io.overflow  = r_ovf;
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub: 32/4, 16/1 and 64/8 instances.
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_add_sub_if #(.WIDTH(32)) bus32 ();
  pipelined_add_sub_if #(.WIDTH(16)) bus16 ();
  pipelined_add_sub_if #(.WIDTH(64)) bus64 ();

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_dut32 (.clk(clk), .rst(rst), .io(bus32));
  pipelined_add_sub #(.WIDTH(16), .STAGES(1)) u_dut16 (.clk(clk), .rst(rst), .io(bus16));
  pipelined_add_sub #(.WIDTH(64), .STAGES(8)) u_dut64 (.clk(clk), .rst(rst), .io(bus64));

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // Streaming vectors with hand-computed 32-bit results
  longint st_a   [8] = '{52, 152, -495955, -451, 4561, 0, -1, 100};
  longint st_b   [8] = '{-31, 2539, -4548, 4498, -89, 0, 1, 100};
  bit     st_cin [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  bit     st_sub [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  longint st_sum [8] = '{21, 2691, -500503, 4047, 4472, 0, 1, 0};
  bit     st_cout[8] = '{1, 0, 1, 1, 1, 0, 1, 1};

  function automatic int unsigned wid(int d);
    case (d)
      0:       return 32;
      1:       return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int stg(int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] mask(int d);
    if (wid(d) == 64) return '1;
    return (64'd1 << wid(d)) - 64'd1;
  endfunction

  function automatic exp_t he(logic [63:0] s, logic c, logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.cyc = 0; e.lat = 1'b0;
    return e;
  endfunction

  // Reference model in wide signed integer arithmetic
  function automatic exp_t model(int d, logic [63:0] a, logic [63:0] b,
                                 logic cin, logic sub, logic sat);
    int unsigned w;
    logic signed [127:0] sa, sb, t, vmax, vmin;
    logic [127:0] ua, ub;
    exp_t e;
    w  = wid(d);
    ua = 128'(a & mask(d));
    ub = 128'(b & mask(d));
    sa = $signed(ua);
    sb = $signed(ub);
    if (a[w-1]) sa = sa - (128'sd1 <<< w);
    if (b[w-1]) sb = sb - (128'sd1 <<< w);
    vmax = (128'sd1 <<< (w - 1)) - 128'sd1;
    vmin = -(128'sd1 <<< (w - 1));
    t = sub ? (sa - sb) : (sa + sb + $signed({127'b0, cin}));
    e.ovf  = (t > vmax) || (t < vmin);
    e.cout = sub ? (ua >= ub) : ((((ua + ub + {127'b0, cin}) >> w) & 128'd1) != 128'd0);
    if (sat && e.ovf) e.sum = 64'((t > vmax) ? vmax : vmin) & mask(d);
    else              e.sum = 64'(t) & mask(d);
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_fail(string name, string act, string req);
    n_chk++;
    $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  task automatic push(int d, exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop(int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic drive(int d, logic v, logic [63:0] a, logic [63:0] b,
                       logic cin, logic sub, logic sat);
    case (d)
      0: begin
        bus32.in_valid = v; bus32.a = a[31:0]; bus32.b = b[31:0];
        bus32.cin = cin; bus32.sub = sub; bus32.sat = sat;
      end
      1: begin
        bus16.in_valid = v; bus16.a = a[15:0]; bus16.b = b[15:0];
        bus16.cin = cin; bus16.sub = sub; bus16.sat = sat;
      end
      default: begin
        bus64.in_valid = v; bus64.a = a; bus64.b = b;
        bus64.cin = cin; bus64.sub = sub; bus64.sat = sat;
      end
    endcase
  endtask

  function automatic logic rdy(int d);
    case (d)
      0:       return bus32.in_ready;
      1:       return bus16.in_ready;
      default: return bus64.in_ready;
    endcase
  endfunction

  // Present one beat, wait for acceptance, record the expected result
  task automatic send(int d, logic [63:0] a, logic [63:0] b, logic cin,
                      logic sub, logic sat, exp_t e, bit lat);
    bit acc;
    int guard;
    int acyc;
    acc = 1'b0; guard = 0; acyc = 0;
    drive(d, 1'b1, a, b, cin, sub, sat);
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc  = rdy(d);
      acyc = cyc;
      @(posedge clk);
      guard++;
    end
    if (!acc) begin
      chk_fail($sformatf("send_timeout_d%0d", d), "in_ready low for 200 cycles", "acceptance");
    end else begin
      e.sum = e.sum & mask(d);
      e.cyc = acyc;
      e.lat = lat;
      push(d, e);
    end
    #1;
    drive(d, 1'b0, a, b, cin, sub, sat);
  endtask

  task automatic mcase(int d, logic [63:0] a, logic [63:0] b, logic cin, logic sub, logic sat);
    send(d, a, b, cin, sub, sat, model(d, a, b, cin, sub, sat), 1'b1);
  endtask

  task automatic stream(int d, bit lat);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      if (d == 1) e = model(d, 64'(st_a[i]), 64'(st_b[i]), st_cin[i], st_sub[i], 1'b0);
      else        e = he(64'(st_sum[i]), st_cout[i], 1'b0);
      send(d, 64'(st_a[i]), 64'(st_b[i]), st_cin[i], st_sub[i], 1'b0, e, lat);
    end
  endtask

  task automatic drain(int d);
    int g;
    g = 0;
    while (qsize(d) != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    if (qsize(d) != 0)
      chk_fail($sformatf("drain_d%0d", d), $sformatf("%0d beats missing", qsize(d)), "0 missing");
    #1;
  endtask

  task automatic mon_one(int d, logic v, logic r, logic [63:0] s, logic c, logic o);
    exp_t e;
    if (!(v && r)) return;
    if (qsize(d) == 0) begin
      chk_fail($sformatf("unexpected_beat_d%0d", d), $sformatf("sum 0x%0h", s), "no beat");
      return;
    end
    e = pop(d);
    chk($sformatf("sum_d%0d", d), s, e.sum);
    chk($sformatf("cout_d%0d", d), 64'(c), 64'(e.cout));
    chk($sformatf("overflow_d%0d", d), 64'(o), 64'(e.ovf));
    if (e.lat) chk($sformatf("latency_d%0d", d), 64'(cyc - e.cyc), 64'(stg(d)));
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_one(0, bus32.out_valid, bus32.out_ready, {32'b0, bus32.sum}, bus32.cout, bus32.overflow);
        mon_one(1, bus16.out_valid, bus16.out_ready, {48'b0, bus16.sum}, bus16.cout, bus16.overflow);
        mon_one(2, bus64.out_valid, bus64.out_ready, bus64.sum, bus64.cout, bus64.overflow);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    bus32.out_ready = 1'b1;
    bus16.out_ready = 1'b1;
    bus64.out_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state is visible before any clock edge
    #2;
    chk("rst_out_valid_d0", 64'(bus32.out_valid), 64'd0);
    chk("rst_out_valid_d1", 64'(bus16.out_valid), 64'd0);
    chk("rst_out_valid_d2", 64'(bus64.out_valid), 64'd0);
    chk("rst_in_ready_d0", 64'(bus32.in_ready), 64'd1);
    chk("rst_sum_d0", {32'b0, bus32.sum}, 64'd0);
    chk("rst_flags_d0", 64'({bus32.cout, bus32.overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Overflow, saturation and carry-in corners on the 32-bit instance
    send(0, 64'h7FFFFFFF, 64'd1, 1'b0, 1'b0, 1'b0, he(64'h80000000, 1'b0, 1'b1), 1'b1);
    send(0, 64'h7FFFFFFF, 64'd1, 1'b0, 1'b0, 1'b1, he(64'h7FFFFFFF, 1'b0, 1'b1), 1'b1);
    send(0, 64'h80000000, 64'd1, 1'b0, 1'b1, 1'b0, he(64'h7FFFFFFF, 1'b1, 1'b1), 1'b1);
    send(0, 64'h80000000, 64'd1, 1'b0, 1'b1, 1'b1, he(64'h80000000, 1'b1, 1'b1), 1'b1);
    send(0, 64'h80000000, 64'hFFFFFFFF, 1'b0, 1'b0, 1'b1, he(64'h80000000, 1'b1, 1'b1), 1'b1);
    send(0, 64'd10, 64'd3, 1'b1, 1'b1, 1'b0, he(64'd7, 1'b1, 1'b0), 1'b1);
    send(0, 64'h40000000, 64'h3FFFFFFF, 1'b1, 1'b0, 1'b1, he(64'h7FFFFFFF, 1'b0, 1'b1), 1'b1);
    stream(0, 1'b1);
    drain(0);

    // Same stream plus corners on the single-stage and eight-stage instances
    stream(1, 1'b1);
    mcase(1, 64'h7FFF, 64'h1, 1'b0, 1'b0, 1'b1);
    mcase(1, 64'h8000, 64'h1, 1'b0, 1'b1, 1'b0);
    drain(1);
    stream(2, 1'b1);
    mcase(2, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 1'b0);
    mcase(2, 64'h8000000000000000, 64'h1, 1'b0, 1'b1, 1'b1);
    mcase(2, 64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000, 1'b1, 1'b0, 1'b0);
    drain(2);

    // Five-cycle output stall in the middle of a stream
    fork
      stream(0, 1'b0);
      begin
        logic [63:0] snap_s;
        logic        snap_c;
        logic        snap_o;
        bit          have;
        int          held;
        have = 1'b0; held = 0; snap_s = '0; snap_c = 1'b0; snap_o = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus32.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (bus32.out_valid) begin
            if (!have) begin
              snap_s = {32'b0, bus32.sum}; snap_c = bus32.cout; snap_o = bus32.overflow;
              have = 1'b1;
            end else begin
              chk("stall_sum_hold", {32'b0, bus32.sum}, snap_s);
              chk("stall_flags_hold", 64'({bus32.cout, bus32.overflow}), 64'({snap_c, snap_o}));
            end
            chk("stall_in_ready", 64'(bus32.in_ready), 64'd0);
            held++;
          end
        end
        chk("stall_cycles_seen", 64'(held), 64'd3);
        @(posedge clk);
        #1 bus32.out_ready = 1'b1;
      end
    join
    drain(0);

    // Asynchronous reset with beats in flight
    send(0, 64'd5, 64'd6, 1'b0, 1'b0, 1'b0, he(64'd11, 1'b0, 1'b0), 1'b0);
    send(0, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0, he(64'd3, 1'b0, 1'b0), 1'b0);
    send(0, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0, he(64'd7, 1'b0, 1'b0), 1'b0);
    send(0, 64'd8, 64'd8, 1'b0, 1'b0, 1'b0, he(64'd16, 1'b0, 1'b0), 1'b0);
    chk("pre_rst_out_valid", 64'(bus32.out_valid), 64'd1);
    chk("pre_rst_sum", {32'b0, bus32.sum}, 64'd11);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(bus32.out_valid), 64'd0);
    chk("async_rst_sum", {32'b0, bus32.sum}, 64'd0);
    chk("async_rst_flags", 64'({bus32.cout, bus32.overflow}), 64'd0);
    chk("async_rst_in_ready", 64'(bus32.in_ready), 64'd1);
    @(negedge clk);
    q0.delete();
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(bus32.in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(bus32.out_valid), 64'd0);
    send(0, 64'd100, 64'd23, 1'b0, 1'b0, 1'b0, he(64'd123, 1'b0, 1'b0), 1'b1);
    drain(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
